// File: rtl/coke_pkg.sv
// coke_pkg: shared types and constants for the coke change dispenser.
//   state_t      : payout FSM states
//   DEN_*        : coin face values in credit units
//   COIN_*       : one-hot hopper codes, bit order {ten,five,two,one}
package coke_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int unsigned DEN_TEN  = 10;
    localparam int unsigned DEN_FIVE = 5;
    localparam int unsigned DEN_TWO  = 2;
    localparam int unsigned DEN_ONE  = 1;

    localparam logic [3:0] COIN_TEN  = 4'b1000;
    localparam logic [3:0] COIN_FIVE = 4'b0100;
    localparam logic [3:0] COIN_TWO  = 4'b0010;
    localparam logic [3:0] COIN_ONE  = 4'b0001;

endpackage

// File: rtl/coke_change_dispenser_inventory.sv
// coin_inventory: per-denomination coin counters and sticky jam flags.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (loads INIT_*, clears jam)
//   load         : reload all counters to INIT_* and clear jam flags
//   dec_onehot   : decrement the selected counter by one
//   jam_onehot   : set the selected jam flag
//   nonempty     : counter != 0, bit order {ten,five,two,one}
//   jam          : sticky jam flags, bit order {ten,five,two,one}
module coin_inventory #(
    parameter int INV_W     = 4,
    parameter int INIT_TEN  = 4,
    parameter int INIT_FIVE = 4,
    parameter int INIT_TWO  = 8,
    parameter int INIT_ONE  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] dec_onehot,
    input  logic [3:0] jam_onehot,
    output logic [3:0] nonempty,
    output logic [3:0] jam
);

    logic [INV_W-1:0] inv [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv[3] <= INV_W'(INIT_TEN);
            inv[2] <= INV_W'(INIT_FIVE);
            inv[1] <= INV_W'(INIT_TWO);
            inv[0] <= INV_W'(INIT_ONE);
            jam    <= '0;
        end else if (load) begin
            inv[3] <= INV_W'(INIT_TEN);
            inv[2] <= INV_W'(INIT_FIVE);
            inv[1] <= INV_W'(INIT_TWO);
            inv[0] <= INV_W'(INIT_ONE);
            jam    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dec_onehot[i]) inv[i] <= inv[i] - INV_W'(1);
                if (jam_onehot[i]) jam[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) nonempty[i] = (inv[i] != '0);
    end

endmodule

// File: rtl/coke_change_dispenser.sv
// coke_change_dispenser: computes change on a vend and pays it out greedily
// (10,5,2,1) through a one-coin-at-a-time hopper handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   vend_start/credit : vend request with total inserted credit (IDLE only)
//   refill            : reload inventories and clear jams (IDLE only, vend wins)
//   coin_valid/coin_sel/coin_ack : hopper request, one-hot coin, hopper ack
//   busy              : payout in progress
//   done              : one-cycle end-of-payout pulse
//   refund/short_change/change_left : payout result, held until next vend
//   jam               : sticky per-denomination jam flags
module coke_change_dispenser
    import coke_pkg::*;
#(
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 6,
    parameter int INV_W       = 4,
    parameter int INIT_TEN    = 4,
    parameter int INIT_FIVE   = 4,
    parameter int INIT_TWO    = 8,
    parameter int INIT_ONE    = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vend_start,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                refill,
    output logic                coin_valid,
    output logic [3:0]          coin_sel,
    input  logic                coin_ack,
    output logic                busy,
    output logic                done,
    output logic                refund,
    output logic                short_change,
    output logic [CREDIT_W-1:0] change_left,
    output logic [3:0]          jam
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] oh);
        case (oh)
            COIN_TEN:  return CREDIT_W'(DEN_TEN);
            COIN_FIVE: return CREDIT_W'(DEN_FIVE);
            COIN_TWO:  return CREDIT_W'(DEN_TWO);
            COIN_ONE:  return CREDIT_W'(DEN_ONE);
            default:   return '0;
        endcase
    endfunction

    state_t              state, state_d;
    logic [CREDIT_W-1:0] remain, remain_d, left_d;
    logic [3:0]          sel_d, pick, dec_oh, jam_oh, nonempty;
    logic [TMR_W-1:0]    tmr, tmr_d;
    logic                cv_d, busy_d, done_d, refund_d, short_d, load;

    coin_inventory #(
        .INV_W(INV_W), .INIT_TEN(INIT_TEN), .INIT_FIVE(INIT_FIVE),
        .INIT_TWO(INIT_TWO), .INIT_ONE(INIT_ONE)
    ) u_inv (
        .clk(clk), .rst_n(rst_n), .load(load),
        .dec_onehot(dec_oh), .jam_onehot(jam_oh),
        .nonempty(nonempty), .jam(jam)
    );

    // Greedy choice: largest coin that fits, is in stock and is not jammed.
    always_comb begin
        pick = '0;
        if (remain >= CREDIT_W'(DEN_TEN) && nonempty[3] && !jam[3])
            pick = COIN_TEN;
        else if (remain >= CREDIT_W'(DEN_FIVE) && nonempty[2] && !jam[2])
            pick = COIN_FIVE;
        else if (remain >= CREDIT_W'(DEN_TWO) && nonempty[1] && !jam[1])
            pick = COIN_TWO;
        else if (remain >= CREDIT_W'(DEN_ONE) && nonempty[0] && !jam[0])
            pick = COIN_ONE;
    end

    always_comb begin
        state_d  = state;
        remain_d = remain;
        sel_d    = coin_sel;
        cv_d     = coin_valid;
        tmr_d    = tmr;
        busy_d   = busy;
        done_d   = 1'b0;
        refund_d = refund;
        short_d  = short_change;
        left_d   = change_left;
        dec_oh   = '0;
        jam_oh   = '0;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vend_start) begin
                    remain_d = (credit >= CREDIT_W'(PRICE)) ? credit - CREDIT_W'(PRICE) : credit;
                    refund_d = (credit < CREDIT_W'(PRICE));
                    short_d  = 1'b0;
                    left_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SELECT;
                end else if (refill) begin
                    load = 1'b1;
                end
            end
            ST_SELECT: begin
                if (remain == '0 || pick == '0) begin
                    done_d  = 1'b1;
                    short_d = (remain != '0);
                    left_d  = remain;
                    state_d = ST_DONE;
                end else begin
                    sel_d   = pick;
                    cv_d    = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // An ack in the final timeout cycle still counts as a payout.
                if (coin_ack) begin
                    dec_oh   = coin_sel;
                    remain_d = remain - coin_value(coin_sel);
                    cv_d     = 1'b0;
                    state_d  = ST_GAP;
                end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                    jam_oh  = coin_sel;
                    cv_d    = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end
            ST_GAP: state_d = ST_SELECT;
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            remain       <= '0;
            coin_sel     <= '0;
            coin_valid   <= 1'b0;
            tmr          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            refund       <= 1'b0;
            short_change <= 1'b0;
            change_left  <= '0;
        end else begin
            state        <= state_d;
            remain       <= remain_d;
            coin_sel     <= sel_d;
            coin_valid   <= cv_d;
            tmr          <= tmr_d;
            busy         <= busy_d;
            done         <= done_d;
            refund       <= refund_d;
            short_change <= short_d;
            change_left  <= left_d;
        end
    end

endmodule

// File: tb/tb_coke_change_dispenser.sv
module tb_coke_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vend_start = 1'b0;
    logic [5:0] credit = '0;
    logic       refill = 1'b0;
    logic       coin_ack = 1'b0;
    logic       coin_valid, busy, done, refund, short_change;
    logic [3:0] coin_sel, jam;
    logic [5:0] change_left;

    int cmp = 0;
    int mis = 0;

    // bench-side inventory model, index 3..0 = ten,five,two,one
    int m_inv [4];
    bit m_jam [4];
    int den_val [4] = '{1, 2, 5, 10};

    logic [3:0] exp_coin_q [$];
    bit         exp_ack_q  [$];

    coke_change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .vend_start(vend_start), .credit(credit),
        .refill(refill), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .coin_ack(coin_ack), .busy(busy), .done(done), .refund(refund),
        .short_change(short_change), .change_left(change_left), .jam(jam)
    );

    always #5 clk = ~clk;

    task automatic model_init();
        m_inv[3] = 4; m_inv[2] = 4; m_inv[1] = 8; m_inv[0] = 8;
        for (int i = 0; i < 4; i++) m_jam[i] = 0;
        exp_coin_q.delete();
        exp_ack_q.delete();
    endtask

    function automatic logic [3:0] model_jam();
        logic [3:0] j;
        for (int i = 0; i < 4; i++) j[i] = m_jam[i];
        return j;
    endfunction

    // Predicts the coin sequence and final result for one vend.
    task automatic predict(input int c, input logic [3:0] noack,
                           output bit e_ref, output bit e_short, output int e_left);
        int rem;
        int pk;
        rem   = (c >= 15) ? c - 15 : c;
        e_ref = (c < 15);
        forever begin
            if (rem == 0) begin e_short = 0; break; end
            pk = -1;
            for (int i = 3; i >= 0; i--)
                if (pk < 0 && den_val[i] <= rem && m_inv[i] > 0 && !m_jam[i]) pk = i;
            if (pk < 0) begin e_short = 1; break; end
            exp_coin_q.push_back(4'(1 << pk));
            exp_ack_q.push_back(!noack[pk]);
            if (noack[pk]) m_jam[pk] = 1;
            else begin rem -= den_val[pk]; m_inv[pk]--; end
        end
        e_left = rem;
    endtask

    // One vend with a hopper that acks ack_delay cycles into each request,
    // except for denominations in noack. poke re-issues vend+refill mid-payout;
    // with_refill raises refill together with the accepted vend_start.
    task automatic do_vend(input int c, input int ack_delay, input logic [3:0] noack,
                           input bit poke, input bit with_refill);
        bit e_ref, e_short, seen_done, acked_exp;
        int e_left, cyc, vcnt, low, ncoins;
        logic [3:0] hold_sel, got;
        predict(c, noack, e_ref, e_short, e_left);
        @(negedge clk);
        vend_start = 1'b1; credit = 6'(c); refill = with_refill;
        @(negedge clk);
        vend_start = 1'b0; refill = 1'b0;
        cmp++;
        if (busy !== 1'b1) begin mis++; $display("FAIL busy_after_vend c=%0d got=%b exp=1", c, busy); end
        cyc = 0; seen_done = 0; vcnt = 0; low = 0; ncoins = 0; acked_exp = 1; hold_sel = '0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            coin_ack = 1'b0;
            if (poke && cyc == 3) begin vend_start = 1'b1; refill = 1'b1; credit = 6'd63; end
            if (cyc == 4) begin vend_start = 1'b0; refill = 1'b0; end
            if (coin_valid) begin
                if (vcnt == 0) begin
                    cmp++;
                    if (exp_coin_q.size() == 0) begin
                        mis++; $display("FAIL unexpected_coin c=%0d got=%b", c, coin_sel);
                        acked_exp = 1;
                    end else begin
                        got = exp_coin_q.pop_front();
                        acked_exp = exp_ack_q.pop_front();
                        if (coin_sel !== got) begin
                            mis++; $display("FAIL coin_sel c=%0d n=%0d got=%b exp=%b", c, ncoins, coin_sel, got);
                        end
                    end
                    cmp++;
                    if (ncoins == 0 && cyc != 1) begin
                        mis++; $display("FAIL first_latency c=%0d got=%0d exp=1", c, cyc);
                    end else if (ncoins > 0 && low != 2) begin
                        mis++; $display("FAIL gap_low_cycles c=%0d got=%0d exp=2", c, low);
                    end
                    hold_sel = coin_sel;
                end else begin
                    cmp++;
                    if (coin_sel !== hold_sel) begin
                        mis++; $display("FAIL coin_sel_stable c=%0d got=%b exp=%b", c, coin_sel, hold_sel);
                    end
                end
                if (acked_exp && vcnt == ack_delay) coin_ack = 1'b1;
                vcnt++;
            end else begin
                if (vcnt > 0) begin
                    if (!acked_exp) begin
                        cmp++;
                        if (vcnt != 16) begin
                            mis++; $display("FAIL timeout_len c=%0d got=%0d exp=16", c, vcnt);
                        end
                    end
                    ncoins++; vcnt = 0; low = 0;
                end
                low++;
            end
            if (done) begin
                seen_done = 1;
                cmp++;
                if (refund !== e_ref || short_change !== e_short || change_left !== 6'(e_left) || busy !== 1'b1) begin
                    mis++;
                    $display("FAIL done_result c=%0d got ref=%b short=%b left=%0d busy=%b exp ref=%b short=%b left=%0d busy=1",
                             c, refund, short_change, change_left, busy, e_ref, e_short, e_left);
                end
            end
        end
        if (!seen_done) begin mis++; cmp++; $display("FAIL done_timeout c=%0d cycles=%0d", c, cyc); end
        cmp++;
        if (exp_coin_q.size() != 0) begin
            mis++; $display("FAIL missing_coins c=%0d got=%0d_left exp=0", c, exp_coin_q.size());
            exp_coin_q.delete(); exp_ack_q.delete();
        end
        @(negedge clk);
        cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || change_left !== 6'(e_left) || refund !== e_ref || jam !== model_jam()) begin
            mis++;
            $display("FAIL after_done c=%0d got done=%b busy=%b left=%0d ref=%b jam=%b exp done=0 busy=0 left=%0d ref=%b jam=%b",
                     c, done, busy, change_left, refund, jam, e_left, e_ref, model_jam());
        end
    endtask

    task automatic do_refill();
        @(negedge clk); refill = 1'b1;
        @(negedge clk); refill = 1'b0;
        model_init();
        cmp++;
        if (jam !== 4'b0000) begin mis++; $display("FAIL refill_jam got=%b exp=0000", jam); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp++;
        if (coin_valid !== 0 || busy !== 0 || done !== 0 || refund !== 0 || short_change !== 0 ||
            change_left !== 0 || jam !== 0 || coin_sel !== 0) begin
            mis++;
            $display("FAIL reset_outputs got cv=%b busy=%b done=%b ref=%b short=%b left=%0d jam=%b sel=%b exp all 0",
                     coin_valid, busy, done, refund, short_change, change_left, jam, coin_sel);
        end
        rst_n = 1'b1;
        model_init();
    endtask

    task automatic test_single_five();
        do_vend(20, 0, 4'b0000, 0, 0);
    endtask

    task automatic test_multi_coin();
        // mid-payout vend/refill must be ignored
        do_vend(28, 2, 4'b0000, 1, 0);
    endtask

    task automatic test_five_empty();
        for (int k = 0; k < 3; k++) do_vend(20, 1, 4'b0000, 0, 0);
        // five stock is now zero; refill alongside vend must lose to the vend
        do_vend(20, 0, 4'b0000, 0, 1);
        do_refill();
    endtask

    task automatic test_short();
        for (int k = 0; k < 8; k++) do_vend(16, 0, 4'b0000, 0, 0);
        for (int k = 0; k < 8; k++) do_vend(17, 0, 4'b0000, 0, 0);
        do_vend(16, 0, 4'b0000, 0, 0);
        do_vend(17, 0, 4'b0000, 0, 0);
        do_refill();
    endtask

    task automatic test_refund();
        do_vend(9, 3, 4'b0000, 0, 0);
        do_vend(0, 0, 4'b0000, 0, 0);
    endtask

    task automatic test_jam();
        do_vend(25, 0, 4'b1000, 0, 0);
        cmp++;
        if (jam !== 4'b1000) begin mis++; $display("FAIL jam_flag got=%b exp=1000", jam); end
        do_vend(35, 0, 4'b0000, 0, 0);
        do_refill();
        do_vend(25, 0, 4'b0000, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_refill();
        do_vend(20, 0, 4'b0000, 0, 0);
        @(negedge clk); vend_start = 1'b1; credit = 6'd20;
        @(negedge clk); vend_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (coin_valid) seen = 1;
        end
        cmp++;
        if (!seen) begin mis++; $display("FAIL mid_request got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        cmp++;
        if (coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            mis++; $display("FAIL async_reset got cv=%b busy=%b done=%b exp 0 0 0", coin_valid, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        model_init();
        // four fives only if the five count was restored to INIT
        for (int k = 0; k < 5; k++) do_vend(20, 0, 4'b0000, 0, 0);
    endtask

    initial begin
        model_init();
        test_reset();
        test_single_five();
        test_multi_coin();
        test_five_empty();
        test_short();
        test_refund();
        test_jam();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule

// File: doc/coke_change_dispenser.md
Name: coke_change_dispenser

Overview:
Downstream stage of the coke vending datapath. On a vend event it computes change as credit minus PRICE, or a full refund if credit is short. It then pays that amount out greedily as coins {10,5,2,1} through a one-coin-at-a-time hopper handshake. It tracks per-denomination coin inventory, handles hopper jams by timeout, and reports any unpaid remainder.

Parameters:
PRICE, 15, cost of one coke in credit units
CREDIT_W, 6, width of credit and remainder
INV_W, 4, width of each inventory counter
INIT_TEN, 4, ten-coins loaded at reset/refill
INIT_FIVE, 4, five-coins loaded at reset/refill
INIT_TWO, 8, two-coins loaded at reset/refill
INIT_ONE, 8, one-coins loaded at reset/refill
ACK_TIMEOUT, 16, cycles to wait for coin_ack before declaring jam

Ports:
clk  in  1  single system clock (the divided vending clock)
rst_n  in  1  reset, asynchronous, active-low
vend_start  in  1  one-cycle pulse; credit is valid this cycle
credit  in  CREDIT_W  total inserted credit
refill  in  1  reload all inventories to INIT_*; honoured only in IDLE
coin_valid  out  1  hopper request, held until ack or timeout
coin_sel  out  4  one-hot {ten,five,two,one}; stable while coin_valid
coin_ack  in  1  hopper has ejected the requested coin
busy  out  1  high from the cycle after accepted vend_start until DONE exits
done  out  1  one-cycle pulse when payout ends
refund  out  1  valid with done: credit < PRICE, full refund made
short_change  out  1  valid with done: remainder could not be paid
change_left  out  CREDIT_W  valid with done: unpaid amount
jam  out  4  sticky per-denomination jam flags; cleared by refill

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; remain=0; inventories=INIT_*; jam=0. Applies immediately, including mid-handshake: coin_valid drops with no decrement.
- States: IDLE, SELECT, WAIT_ACK, GAP, DONE.
- IDLE, vend_start=1:
  - remain <= (credit>=PRICE) ? credit-PRICE : credit.
  - refund <= (credit<PRICE).
  - Next state SELECT.
  - If vend_start and refill arrive in the same cycle, vend wins and refill is ignored.
- vend_start outside IDLE is ignored, with no queueing.
- SELECT (one cycle, combinational choice):
  - remain==0 -> DONE with short_change=0.
  - Otherwise pick the largest d in {10,5,2,1} with d<=remain, inv[d]>0 and jam[d]=0.
  - No candidate -> DONE with short_change=1.
  - Candidate found -> next cycle coin_valid=1, coin_sel=onehot(d), state WAIT_ACK, timer cleared.
- WAIT_ACK:
  - coin_valid and coin_sel are held.
  - coin_ack sampled high -> remain-=d, inv[d]-=1, coin_valid=0, go to GAP.
  - Timer reaches ACK_TIMEOUT with no ack -> jam[d]=1, no decrement, coin_valid=0, go to GAP.
  - coin_ack while coin_valid=0 is ignored.
- GAP: one cycle with coin_valid low, guaranteed between requests; then SELECT.
- DONE:
  - done=1 for one cycle; change_left=remain; refund and short_change valid.
  - These three outputs hold until the next accepted vend_start.
  - Next state IDLE; busy=0 in IDLE.
- Arithmetic: remain never underflows because d<=remain. Inventories never go below 0 because inv>0 is required to select.
- Latency: vend_start -> first coin_valid is 2 cycles. Each coin costs 1 + (ack wait) + 1 cycles.

Decomposition:
- Shared package coke_pkg:
  - state enum.
  - Denomination values DEN_TEN=10, DEN_FIVE=5, DEN_TWO=2, DEN_ONE=1.
  - One-hot coin codes matching the coin input order {ten,five,two,one}.
- Sub-module coin_inventory:
  - Four INV_W counters plus the jam flags.
  - Inputs: load (refill/reset), dec_onehot, jam_onehot.
  - Outputs: nonempty[3:0], jam[3:0].
- The FSM, selection logic and timeout counter stay in the top module.

Test Plan:
1. credit=20, ack 1 cycle after each request -> coin_sel=0100 once; done with change_left=0, refund=0, short_change=0; inv_five 4->3.
2. credit=28 -> requests ten, two, one in order; exactly one GAP cycle between them; done, change_left=0.
3. Five inventory emptied via prior vends, then credit=20 -> two, two, one paid; short_change=0.
4. One and two inventories empty, credit=16 -> no coin_valid; done with short_change=1, change_left=1.
5. credit=9 -> refund=1; coins five, two, two; change_left=0.
6. credit=25, coin_ack held low -> coin_valid drops after 16 cycles; jam=1000; then five, five paid; next refill clears jam.
7. Extra check: rst_n low during WAIT_ACK -> coin_valid=0 and busy=0 immediately, inventories back to INIT.
